// File: rtl/mm_autosolver_if.sv
// Guess/score handshake between the Mastermind solver (master) and the scorer (slave).
interface mm_autosolver_if;
  logic [2:0] guess0;
  logic [2:0] guess1;
  logic [2:0] guess2;
  logic [2:0] guess3;
  logic       guess_valid;
  logic       fb_valid;
  logic [2:0] fb_exact;
  logic [2:0] fb_partial;

  modport master (
    output guess0, guess1, guess2, guess3, guess_valid,
    input  fb_valid, fb_exact, fb_partial
  );

  modport slave (
    input  guess0, guess1, guess2, guess3, guess_valid,
    output fb_valid, fb_exact, fb_partial
  );
endinterface

// File: rtl/mm_autosolver.sv
// Mastermind auto-solver: walks candidates 0..4095 and presents the first one consistent with all scored history.
// Define MM_SOLVER_FIXED_OPENER_EN to open every game with the fixed guess 0,0,1,1 instead of searching.
module mm_autosolver #(
  parameter int unsigned MAX_TURNS = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  mm_autosolver_if.master game,
  output logic [2:0]     turn,
  output logic           solved,
  output logic           failed,
  output logic           error,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, SEARCH, PRESENT, WON, LOST, ERR} state_t;

  localparam logic [3:0] TURN_LIMIT = 4'(MAX_TURNS);

  state_t      state;
  logic [11:0] cand;
  logic [11:0] guess;
  logic        guess_valid;
  logic [2:0]  idx;

  logic [11:0] hist_guess   [8];
  logic [2:0]  hist_exact   [8];
  logic [2:0]  hist_partial [8];

  logic [11:0] hguess;
  logic [2:0]  sc_exact;
  logic [2:0]  sc_common;
  logic [2:0]  sc_partial;
  logic        entry_match;
  logic [3:0]  turn_next;

  assign game.guess0      = guess[2:0];
  assign game.guess1      = guess[5:3];
  assign game.guess2      = guess[8:6];
  assign game.guess3      = guess[11:9];
  assign game.guess_valid = guess_valid;

  assign turn_next = {1'b0, turn} + 4'd1;

  // Score the current candidate against history entry idx.
  always_comb begin
    logic [2:0] n_g;
    logic [2:0] n_c;
    hguess    = hist_guess[idx];
    sc_exact  = '0;
    sc_common = '0;
    n_g       = '0;
    n_c       = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      if (cand[3*p +: 3] == hguess[3*p +: 3]) sc_exact = sc_exact + 3'd1;
    end
    for (int unsigned col = 0; col < 8; col++) begin
      n_g = '0;
      n_c = '0;
      for (int unsigned p = 0; p < 4; p++) begin
        if (hguess[3*p +: 3] == 3'(col)) n_g = n_g + 3'd1;
        if (cand[3*p +: 3]   == 3'(col)) n_c = n_c + 3'd1;
      end
      sc_common = sc_common + ((n_g < n_c) ? n_g : n_c);
    end
    sc_partial  = sc_common - sc_exact;
    entry_match = (sc_exact == hist_exact[idx]) && (sc_partial == hist_partial[idx]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cand        <= '0;
      guess       <= '0;
      guess_valid <= 1'b0;
      idx         <= '0;
      turn        <= '0;
      solved      <= 1'b0;
      failed      <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        hist_guess[i]   <= '0;
        hist_exact[i]   <= '0;
        hist_partial[i] <= '0;
      end
    end else if (start) begin
      state       <= SEARCH;
      cand        <= '0;
      guess_valid <= 1'b0;
      idx         <= '0;
      turn        <= '0;
      solved      <= 1'b0;
      failed      <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
        hist_guess[i]   <= '0;
        hist_exact[i]   <= '0;
        hist_partial[i] <= '0;
      end
    end else begin
      case (state)
        SEARCH: begin
          // idx reaching turn means every recorded entry agreed with this candidate.
          if (idx == turn) begin
`ifdef MM_SOLVER_FIXED_OPENER_EN
            guess <= (turn == 3'd0) ? 12'o0011 : cand;
`else
            guess <= cand;
`endif
            guess_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= PRESENT;
          end else if (entry_match) begin
            idx <= idx + 3'd1;
          end else if (cand == '1) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else begin
            cand <= cand + 12'd1;
            idx  <= '0;
          end
        end
        PRESENT: begin
          if (game.fb_valid) begin
            hist_guess[turn]   <= guess;
            hist_exact[turn]   <= game.fb_exact;
            hist_partial[turn] <= game.fb_partial;
            turn               <= turn_next[2:0];
            guess_valid        <= 1'b0;
            idx                <= '0;
            if (game.fb_exact == 3'd4) begin
              solved <= 1'b1;
              state  <= WON;
            end else if (turn_next == TURN_LIMIT) begin
              failed <= 1'b1;
              state  <= LOST;
`ifdef MM_SOLVER_FIXED_OPENER_EN
            end else if (turn == 3'd0) begin
              // The opener was not a searched candidate, so the scan starts at 0.
              busy  <= 1'b1;
              state <= SEARCH;
`endif
            end else if (cand == '1) begin
              error <= 1'b1;
              state <= ERR;
            end else begin
              cand  <= cand + 12'd1;
              busy  <= 1'b1;
              state <= SEARCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mm_autosolver.md
MM_AUTOSOLVER -- requirements
Module: mm_autosolver

Interface
REQ-001 SHALL have parameter MAX_TURNS, default 8, giving the guess limit per game (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins a new game.
REQ-005 SHALL have ports guess0..guess3, output, 3 bits each: proposed code colours; candidate index c maps guess0=c[2:0], guess1=c[5:3], guess2=c[8:6], guess3=c[11:9].
REQ-006 SHALL have port guess_valid, output, 1 bit: guess0..guess3 are stable and awaiting score.
REQ-007 SHALL have ports fb_valid (1 bit), fb_exact (3 bits) and fb_partial (3 bits), inputs: score for the presented guess.
REQ-008 SHALL have port turn, output, 3 bits: count of scored guesses in the current game.
REQ-009 SHALL have ports solved, failed, error and busy, outputs, 1 bit each: game won, turn limit hit, feedback inconsistent, searching.

Function
REQ-010 SHALL implement states IDLE, SEARCH, PRESENT, WON, LOST and ERR.
REQ-011 SHALL, on start in any state, clear history, set turn=0, candidate=0 and clear solved/failed/error, then enter SEARCH on the next edge.
REQ-012 SHALL, in SEARCH, score the candidate against one stored history entry per cycle: exact = positional matches; partial = sum over colours of min(count in guess, count in candidate) minus exact.
REQ-013 SHALL reject a candidate on the first entry whose (exact, partial) differs from the stored feedback, and SHALL advance to candidate+1 on the next cycle.
REQ-014 SHALL enter PRESENT one cycle after a candidate matches all turn entries; with turn=0, this occurs on the first SEARCH cycle.
REQ-015 SHALL resume each new search from the last presented candidate+1, never revisiting lower indices within a game.
REQ-016 SHALL enter ERR with error=1 if the candidate would wrap past 4095 without a match.
REQ-017 SHALL, in PRESENT, hold guess_valid=1 with constant guesses until fb_valid=1 is sampled.
REQ-018 SHALL store the accepted guess and feedback in history entry turn, increment turn, and drop guess_valid on the following cycle.
REQ-019 SHALL ignore fb_valid whenever guess_valid=0.
REQ-020 SHALL, on accepted feedback with fb_exact=4, enter WON (solved=1), taking precedence over the turn limit.
REQ-021 SHALL otherwise, on accepted feedback, enter LOST (failed=1) if the incremented turn equals MAX_TURNS, else return to SEARCH.
REQ-022 SHALL treat fb_exact+fb_partial>4 as an ordinary mismatching value, with no special handling.
REQ-023 SHALL hold busy=1 only in SEARCH.
REQ-024 SHALL remain in WON, LOST and ERR until start or reset.
REQ-025 SHALL assert guess_valid at cycle N+2 when start is sampled at cycle N.

Reset
REQ-026 SHALL, on reset_n=0, asynchronously enter IDLE with guess0..guess3=0, guess_valid=0, turn=0, solved=failed=error=busy=0, candidate=0 and history cleared.
REQ-027 SHALL abandon any search or pending handshake on reset mid-operation, with no feedback recorded.

Configuration
REQ-028 SHALL, with macro MM_SOLVER_FIXED_OPENER_EN defined, present guess3=0, guess2=0, guess1=1, guess0=1 as the turn-0 guess without searching, keeping N+2 latency, with the turn-1 search starting at candidate 0.
REQ-029 SHALL, without MM_SOLVER_FIXED_OPENER_EN, produce the turn-0 guess by search, which yields candidate 0 (all zeros).

Verification
REQ-030 SHALL be verified by: reset, start at cycle N -> guess_valid=1 at N+2, guesses 0,0,0,0, turn=0; with macro -> guess1=guess0=1.
REQ-031 SHALL be verified by: first guess scored exact=4 -> solved=1, turn=1, guess_valid=0, state held until next start.
REQ-032 SHALL be verified by: secret guess0=1, others 0; guess 0000 scored 3/0 -> second guess guess0=1, others 0; scored 4/0 -> solved, turn=2.
REQ-033 SHALL be verified by: guess 0000 scored exact=0, partial=1 -> exhaustive search, then error=1, busy=0, guess_valid never reasserted.
REQ-034 SHALL be verified by: MAX_TURNS=2, secret 7777; 0000 scored 0/0 -> next guess 1111; scored 0/0 -> failed=1, turn=2.
REQ-035 SHALL be verified by: fb_valid pulsed during SEARCH -> ignored; start mid-SEARCH -> turn=0 and guess 0000 two cycles later; reset_n low during PRESENT -> all outputs 0 immediately.
